cordic_arbiter: RTL and testbench

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_pkg.sv | 43 ++++
 rtl/cordic_tag_pipe.sv | 42 ++++
 rtl/cordic_arbiter.sv | 140 ++++++++++++++
 tb/tb_cordic_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Brief    : Shared widths, latency and tag record for the CORDIC arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int ARG_W          = 16;
    localparam int OUT_W          = 14;
    localparam int CORDIC_LATENCY = 14;
    localparam int CNT_W          = 4;
    localparam int TAG_ID_W       = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Round-robin pick over up to 8 requesters: returns {found, index}.
    // The lowest offset from ptr wins, so scanning downward lets it overwrite.
    function automatic logic [3:0] rr_pick(input logic [7:0] elig,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [3:0] res;
        int         j;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (elig[3'(j)]) begin
                    res = {1'b1, 3'(j)};
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cordic_tag_pipe
// Brief    : Free-running {valid, id} delay line tracking results in flight.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_tag_pipe
    import cordic_pkg::*;
#(
    parameter int DEPTH = CORDIC_LATENCY + 1,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id
);

    logic [DEPTH-1:0]           r_valid;
    logic [DEPTH-1:0][ID_W-1:0] r_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_id    <= '0;
        end else begin
            r_valid[0] <= in_valid;
            r_id[0]    <= in_id;
            for (int s = 1; s < DEPTH; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_id[s]    <= r_id[s-1];
            end
        end
    end

    assign out_valid = r_valid[DEPTH-1];
    assign out_id    = r_id[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cordic_arbiter
// Brief    : Round-robin, credit-limited front end sharing one CORDIC pipe.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  LATENCY = CORDIC_LATENCY,
    parameter int  MAX_OUT = 4,
    localparam int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [ARG_W*N_REQ-1:0] req_arg,
    output logic [N_REQ-1:0]       req_ready,
    output logic [ARG_W-1:0]       cordic_arg,
    input  logic [OUT_W-1:0]       cordic_re,
    input  logic [OUT_W-1:0]       cordic_im,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [OUT_W-1:0]       rsp_re,
    output logic [OUT_W-1:0]       rsp_im,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] c_max_out = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0] r_out [N_REQ];
    logic [ID_W-1:0]  r_ptr;
    logic [ARG_W-1:0] r_arg;
    tag_t             r_issue;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [OUT_W-1:0] r_rsp_re;
    logic [OUT_W-1:0] r_rsp_im;

    logic [N_REQ-1:0] w_retire;
    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_nz;
    logic [N_REQ-1:0] w_ready;
    logic [7:0]       w_elig8;
    logic [3:0]       w_pick;
    logic             w_accept;
    logic [ID_W-1:0]  w_gnt_idx;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [ARG_W-1:0] w_gnt_arg;
    logic             w_pipe_valid;
    logic [ID_W-1:0]  w_pipe_id;

    // A credit returning this cycle is usable this cycle, so a full
    // requester can be granted on the same edge its oldest result retires.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_retire[gi] = r_rsp_valid && (r_rsp_id == ID_W'(gi));
            assign w_elig[gi]   = req_valid[gi] &&
                                  ((r_out[gi] < c_max_out) || w_retire[gi]);
            assign w_ready[gi]  = w_accept && (w_gnt_idx == ID_W'(gi));
            assign w_nz[gi]     = |r_out[gi];
        end
    endgenerate

    always_comb begin
        w_elig8              = '0;
        w_elig8[N_REQ-1:0]   = w_elig;
        w_pick               = rr_pick(w_elig8, 3'(r_ptr), N_REQ);
        w_accept             = !rst && w_pick[3];
        w_gnt_idx            = ID_W'(w_pick[2:0]);
        w_ptr_nxt            = (w_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        w_gnt_arg            = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_idx == ID_W'(i)) begin
                w_gnt_arg = req_arg[ARG_W*i +: ARG_W];
            end
        end
    end

    // The issue tag sits beside cordic_arg, so the pipe output lines up with
    // the datapath result one cycle before the response register.
    cordic_tag_pipe #(
        .DEPTH (LATENCY + 1),
        .ID_W  (ID_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (r_issue.valid),
        .in_id     (ID_W'(r_issue.id)),
        .out_valid (w_pipe_valid),
        .out_id    (w_pipe_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_arg       <= '0;
            r_issue     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_re    <= '0;
            r_rsp_im    <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_out[i] <= '0;
            end
        end else begin
            r_issue.valid <= w_accept;
            r_issue.id    <= TAG_ID_W'(w_gnt_idx);
            if (w_accept) begin
                r_arg <= w_gnt_arg;
                r_ptr <= w_ptr_nxt;
            end
            r_rsp_valid <= w_pipe_valid;
            if (w_pipe_valid) begin
                r_rsp_id <= w_pipe_id;
                r_rsp_re <= cordic_re;
                r_rsp_im <= cordic_im;
            end
            for (int i = 0; i < N_REQ; i++) begin
                case ({w_ready[i], w_retire[i]})
                    2'b10:   r_out[i] <= r_out[i] + 1'b1;
                    2'b01:   r_out[i] <= r_out[i] - 1'b1;
                    default: r_out[i] <= r_out[i];
                endcase
            end
        end
    end

    assign req_ready  = w_ready;
    assign cordic_arg = r_arg;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_re     = r_rsp_re;
    assign rsp_im     = r_rsp_im;
    assign busy       = |w_nz;

endmodule
`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_arbiter
// Brief    : Self-checking bench with a stand-in CORDIC and response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_arbiter;

    localparam int NR  = 4;
    localparam int LAT = 14;
    localparam int MO  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] args [4];
    logic [63:0] req_arg;
    logic [3:0]  req_ready;
    logic [15:0] cordic_arg;
    logic [13:0] cordic_re;
    logic [13:0] cordic_im;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [13:0] rsp_re;
    logic [13:0] rsp_im;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int          id;
        logic [15:0] arg;
        int          due;
    } exp_t;
    exp_t q[$];

    int   m_ptr;
    int   m_out [4];
    logic m_retire;
    int   m_rid;
    int   m_gnt;
    logic [3:0] m_rdy;
    logic m_busy;
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign req_arg = {args[3], args[2], args[1], args[0]};

    // Stand-in datapath: result valid LAT cycles after it samples cordic_arg.
    logic [15:0] cm [0:LAT];
    always @(posedge clk) begin
        cm[0] <= cordic_arg;
        for (int s = 1; s <= LAT; s++) cm[s] <= cm[s-1];
    end
    assign cordic_re = cm[LAT][15:2];
    assign cordic_im = cm[LAT][13:0] ^ 14'h2AAA;

    function automatic logic [13:0] f_re(input logic [15:0] a);
        return a[15:2];
    endfunction
    function automatic logic [13:0] f_im(input logic [15:0] a);
        return a[13:0] ^ 14'h2AAA;
    endfunction

    cordic_arbiter #(.N_REQ(NR), .LATENCY(LAT), .MAX_OUT(MO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_arg    (req_arg),
        .req_ready  (req_ready),
        .cordic_arg (cordic_arg),
        .cordic_re  (cordic_re),
        .cordic_im  (cordic_im),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_re     (rsp_re),
        .rsp_im     (rsp_im),
        .busy       (busy)
    );

    // Reference arbiter + scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            m_retire = (q.size() > 0) && (q[0].due == cyc);
            checks++;
            if (rsp_valid !== m_retire) begin
                failures++;
                $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, m_retire);
            end
            m_rid = -1;
            if (m_retire) begin
                e = q.pop_front();
                m_rid = e.id;
                if (rsp_valid === 1'b1) begin
                    checks++;
                    if (rsp_id !== 2'(e.id) || rsp_re !== f_re(e.arg) || rsp_im !== f_im(e.arg)) begin
                        failures++;
                        $display("FAIL rsp_data cyc=%0d got id=%0d re=%h im=%h exp id=%0d re=%h im=%h",
                                 cyc, rsp_id, rsp_re, rsp_im, e.id, f_re(e.arg), f_im(e.arg));
                    end
                end
            end
            m_busy = 1'b0;
            for (int i = 0; i < NR; i++) if (m_out[i] != 0) m_busy = 1'b1;
            checks++;
            if (busy !== m_busy) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy);
            end
            m_rdy = 4'b0000;
            m_gnt = -1;
            if (!rst) begin
                for (int k = 0; k < NR; k++) begin
                    int j;
                    j = (m_ptr + k) % NR;
                    if (m_gnt < 0 && req_valid[j] && (m_out[j] < MO || m_rid == j)) m_gnt = j;
                end
                if (m_gnt >= 0) m_rdy[m_gnt] = 1'b1;
            end
            checks++;
            if (req_ready !== m_rdy) begin
                failures++;
                $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_rdy);
            end
            if (rst) begin
                m_ptr = 0;
                for (int i = 0; i < NR; i++) m_out[i] = 0;
                q.delete();
            end else begin
                if (m_rid >= 0) m_out[m_rid]--;
                if (m_gnt >= 0) begin
                    m_out[m_gnt]++;
                    m_ptr = (m_gnt + 1) % NR;
                    q.push_back('{id: m_gnt, arg: args[m_gnt], due: cyc + 17});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req_valid = 4'b0000;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && q.size() != 0; k++) tick();
        @(negedge clk);
        checks++;
        if (q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drain pending=%0d busy=%b exp pending=0 busy=0", q.size(), busy);
        end
        tick();
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        tick();
        mon_en = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0 || cordic_arg !== 16'h0 ||
            rsp_id !== 2'd0 || rsp_re !== 14'h0 || rsp_im !== 14'h0) begin
            failures++;
            $display("FAIL reset_state got rdy=%b rv=%b busy=%b arg=%h id=%0d re=%h im=%h exp all zero",
                     req_ready, rsp_valid, busy, cordic_arg, rsp_id, rsp_re, rsp_im);
        end
        tick();
        rst = 1'b0;
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_single();
        int   t0;
        logic got;
        args[2] = 16'h4000;
        req_valid = 4'b0100;
        @(negedge clk);
        t0 = cyc;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_ready got=%b exp=0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        checks++;
        if (cordic_arg !== 16'h4000) begin
            failures++;
            $display("FAIL single_arg got=%h exp=4000", cordic_arg);
        end
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got || (cyc - t0 - 1) != 16 || rsp_id !== 2'd2 || rsp_re !== 14'h1000 || rsp_im !== 14'h2AAA) begin
            failures++;
            $display("FAIL single_rsp got seen=%b lat=%0d id=%0d re=%h im=%h exp seen=1 lat=16 id=2 re=1000 im=2aaa",
                     got, cyc - t0 - 1, rsp_id, rsp_re, rsp_im);
        end
        drain();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset(2);
        for (int i = 0; i < NR; i++) args[i] = 16'($urandom);
        req_valid = 4'b1111;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k < 16)       exp = 4'b0001 << (k % 4);
            else if (k == 16) exp = 4'b0000;
            else              exp = 4'b0001;
            checks++;
            if (req_ready !== exp) begin
                failures++;
                $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, exp);
            end
            tick();
            for (int i = 0; i < NR; i++) args[i] = 16'($urandom);
        end
        for (int k = 0; k < 30; k++) begin
            tick();
            for (int i = 0; i < NR; i++) args[i] = 16'($urandom);
        end
        req_valid = 4'b0000;
        drain();
    endtask

    task automatic test_credit();
        logic exp;
        do_reset(1);
        req_valid = 4'b0001;
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            exp = (k < 4) || (k >= 17);
            checks++;
            if (req_ready[0] !== exp || (k == 17 && rsp_valid !== 1'b1)) begin
                failures++;
                $display("FAIL credit k=%0d got rdy=%b rv=%b exp rdy=%b", k, req_ready[0], rsp_valid, exp);
            end
            tick();
            args[0] = 16'($urandom);
        end
        req_valid = 4'b0000;
        drain();
    endtask

    task automatic test_reset_midflight();
        args[2] = 16'h1234;
        req_valid = 4'b0100;
        repeat (3) tick();
        req_valid = 4'b0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midreset k=%0d got rv=%b busy=%b exp rv=0 busy=0", k, rsp_valid, busy);
            end
            tick();
        end
        req_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL ptr_restart got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        drain();
    endtask

    task automatic test_sweep();
        int   n_acc = 0;
        int   n_rsp = 0;
        logic acc;
        args[1] = 16'h0000;
        req_valid = 4'b0010;
        for (int k = 0; k < 20000 && n_rsp < 1024; k++) begin
            @(negedge clk);
            acc = req_ready[1];
            if (rsp_valid === 1'b1 && rsp_id === 2'd1) n_rsp++;
            tick();
            if (acc) begin
                n_acc++;
                args[1] = args[1] + 16'd64;
                if (n_acc == 1024) req_valid = 4'b0000;
            end
        end
        req_valid = 4'b0000;
        checks++;
        if (n_rsp != 1024 || n_acc != 1024) begin
            failures++;
            $display("FAIL sweep got acc=%0d rsp=%0d exp 1024/1024", n_acc, n_rsp);
        end
        drain();
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'b0000;
        for (int i = 0; i < NR; i++) args[i] = 16'h0;
        m_ptr = 0;
        for (int i = 0; i < NR; i++) m_out[i] = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_credit();
        test_reset_midflight();
        test_sweep();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL leftover got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
